// File: rtl/sensor_snapshot_bank_if.sv
// Request/display bus between the snapshot bank, its requesters and the VGA side.
interface sensor_snapshot_bank_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SLOTS  = 8
);
  localparam int unsigned SLOT_W = $clog2(SLOTS);

  logic [DATA_W-1:0] sensor_input;
  logic [SLOT_W-1:0] slot_sel;
  logic              save_req;
  logic              load_req;
  logic              play_req;
  logic              live_req;
  logic              clear_req;
  logic [DATA_W-1:0] display_data;
  logic [1:0]        mode;
  logic [SLOT_W-1:0] cur_slot;
  logic [SLOTS-1:0]  valid_mask;
  logic              save_signal;
  logic              load_signal;
  logic              err_signal;

  // Requester side: drives sensor word and requests, observes display/status.
  modport master (
    output sensor_input, slot_sel, save_req, load_req, play_req, live_req, clear_req,
    input  display_data, mode, cur_slot, valid_mask, save_signal, load_signal, err_signal
  );

  // Snapshot bank side.
  modport slave (
    input  sensor_input, slot_sel, save_req, load_req, play_req, live_req, clear_req,
    output display_data, mode, cur_slot, valid_mask, save_signal, load_signal, err_signal
  );
endinterface

// File: rtl/sensor_snapshot_bank.sv
// Multi-slot sensor snapshot bank: live view, held snapshot, or timed replay
// of all stored snapshots, with one-cycle save/load/error pulses.
module sensor_snapshot_bank #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic                   clock,
  input logic                   reset,
  sensor_snapshot_bank_if.slave bus
);
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam int unsigned REQ_N     = 5;
  localparam int unsigned REQ_SAVE  = 0;
  localparam int unsigned REQ_LOAD  = 1;
  localparam int unsigned REQ_PLAY  = 2;
  localparam int unsigned REQ_LIVE  = 3;
  localparam int unsigned REQ_CLEAR = 4;

  typedef enum logic [1:0] {
    MODE_LIVE = 2'b00,
    MODE_HOLD = 2'b01,
    MODE_PLAY = 2'b10
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
  logic [SLOTS-1:0]  valid_q, valid_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              save_q, save_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic [REQ_N-1:0]  req_hist_q;
  logic [REQ_N-1:0]  req_c;
  logic [REQ_N-1:0]  edge_c;
  logic              mem_we_c;
  logic [SLOT_W-1:0] lowest_c;
  logic [SLOT_W-1:0] next_c;
  logic              found_next_c;
  logic [DATA_W-1:0] mem_q [SLOTS];

  assign req_c  = {bus.clear_req, bus.live_req, bus.play_req, bus.load_req, bus.save_req};
  assign edge_c = req_c & ~req_hist_q;

  // Lowest valid slot, and next valid slot above the current one (wrapping).
  always_comb begin
    lowest_c     = '0;
    next_c       = '0;
    found_next_c = 1'b0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (valid_q[i]) begin
        lowest_c = SLOT_W'(i);
        if (i > int'(cur_slot_q)) begin
          next_c       = SLOT_W'(i);
          found_next_c = 1'b1;
        end
      end
    end
    if (!found_next_c) begin
      next_c = lowest_c;
    end
  end

  // Next-state: prioritised request handling, replay stepping, display select.
  always_comb begin
    mode_d     = mode_q;
    cur_slot_d = cur_slot_q;
    valid_d    = valid_q;
    tick_d     = '0;
    save_d     = 1'b0;
    load_d     = 1'b0;
    err_d      = 1'b0;
    mem_we_c   = 1'b0;
    display_d  = (mode_q == MODE_LIVE) ? bus.sensor_input : mem_q[cur_slot_q];

    if (edge_c[REQ_CLEAR]) begin
      valid_d    = '0;
      mode_d     = MODE_LIVE;
      cur_slot_d = '0;
    end else if (edge_c[REQ_LIVE]) begin
      mode_d = MODE_LIVE;
    end else if (edge_c[REQ_PLAY]) begin
      if (valid_q == '0) begin
        err_d = 1'b1;
      end else begin
        mode_d     = MODE_PLAY;
        cur_slot_d = lowest_c;
        load_d     = 1'b1;
      end
    end else begin
      // Replay stepping keeps running unless a request changes the mode.
      if (mode_q == MODE_PLAY) begin
        if (tick_q == TICK_LAST) begin
          cur_slot_d = next_c;
          load_d     = 1'b1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      if (edge_c[REQ_LOAD]) begin
        if (valid_q[bus.slot_sel]) begin
          mode_d     = MODE_HOLD;
          cur_slot_d = bus.slot_sel;
          load_d     = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (edge_c[REQ_SAVE]) begin
        if (mode_q == MODE_PLAY) begin
          err_d = 1'b1;
        end else begin
          mem_we_c              = 1'b1;
          valid_d[bus.slot_sel] = 1'b1;
          save_d                = 1'b1;
        end
      end
    end

    if (mode_d != MODE_PLAY) begin
      tick_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q     <= MODE_LIVE;
      cur_slot_q <= '0;
      valid_q    <= '0;
      tick_q     <= '0;
      display_q  <= '0;
      save_q     <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      req_hist_q <= '1;
    end else begin
      mode_q     <= mode_d;
      cur_slot_q <= cur_slot_d;
      valid_q    <= valid_d;
      tick_q     <= tick_d;
      display_q  <= display_d;
      save_q     <= save_d;
      load_q     <= load_d;
      err_q      <= err_d;
      req_hist_q <= req_c;
    end
  end

  // Snapshot storage; contents are not reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we_c) begin
      mem_q[bus.slot_sel] <= bus.sensor_input;
    end
  end

  assign bus.display_data = display_q;
  assign bus.mode         = mode_q;
  assign bus.cur_slot     = cur_slot_q;
  assign bus.valid_mask   = valid_q;
  assign bus.save_signal  = save_q;
  assign bus.load_signal  = load_q;
  assign bus.err_signal   = err_q;
endmodule

// File: tb/tb_sensor_snapshot_bank.sv
// Directed table-driven bench for sensor_snapshot_bank (4 slots, 4-cycle replay step).
module tb_sensor_snapshot_bank;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned TICK_DIV = 4;

  typedef struct {
    logic [23:0] sens;
    logic [1:0]  slot;
    logic [4:0]  req;      // {clear, live, play, load, save}
    logic [23:0] e_disp;
    logic [1:0]  e_mode;
    logic [1:0]  e_cur;
    logic [3:0]  e_valid;
    logic [2:0]  e_pls;    // {save_signal, load_signal, err_signal}
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  sensor_snapshot_bank_if #(.DATA_W(DATA_W), .SLOTS(SLOTS)) bus ();

  sensor_snapshot_bank #(
    .DATA_W  (DATA_W),
    .SLOTS   (SLOTS),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [23:0] sens, input logic [1:0] slot,
                              input logic [4:0] req, input logic [23:0] e_disp,
                              input logic [1:0] e_mode, input logic [1:0] e_cur,
                              input logic [3:0] e_valid, input logic [2:0] e_pls);
    vec_t v;
    v.sens = sens; v.slot = slot; v.req = req; v.e_disp = e_disp;
    v.e_mode = e_mode; v.e_cur = e_cur; v.e_valid = e_valid; v.e_pls = e_pls;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input vec_t v);
    chk("display_data", idx, 32'(bus.display_data), 32'(v.e_disp));
    chk("mode",         idx, 32'(bus.mode),         32'(v.e_mode));
    chk("cur_slot",     idx, 32'(bus.cur_slot),     32'(v.e_cur));
    chk("valid_mask",   idx, 32'(bus.valid_mask),   32'(v.e_valid));
    chk("pulses",       idx, 32'({bus.save_signal, bus.load_signal, bus.err_signal}),
        32'(v.e_pls));
  endtask

  // Drive one vector after the previous edge, then sample 1 time unit past the next edge.
  task automatic apply(input int idx, input vec_t v);
    bus.sensor_input = v.sens;
    bus.slot_sel     = v.slot;
    bus.clear_req    = v.req[4];
    bus.live_req     = v.req[3];
    bus.play_req     = v.req[2];
    bus.load_req     = v.req[1];
    bus.save_req     = v.req[0];
    @(posedge clock);
    #1;
    check_outs(idx, v);
  endtask

  initial begin
    // Main flow: save, hold, load error, replay over slots 0,2,3, clear priority.
    vecs.push_back(mk(24'hABCDEF, 2'd0, 5'b00000, 24'hABCDEF, 2'd0, 2'd0, 4'h0, 3'b000));
    vecs.push_back(mk(24'hABCDEF, 2'd2, 5'b00001, 24'hABCDEF, 2'd0, 2'd0, 4'h4, 3'b100));
    vecs.push_back(mk(24'hABCDEF, 2'd2, 5'b00000, 24'hABCDEF, 2'd0, 2'd0, 4'h4, 3'b000));
    vecs.push_back(mk(24'h123456, 2'd2, 5'b00010, 24'h123456, 2'd1, 2'd2, 4'h4, 3'b010));
    vecs.push_back(mk(24'h123456, 2'd2, 5'b00000, 24'hABCDEF, 2'd1, 2'd2, 4'h4, 3'b000));
    vecs.push_back(mk(24'h123456, 2'd1, 5'b00010, 24'hABCDEF, 2'd1, 2'd2, 4'h4, 3'b001));
    vecs.push_back(mk(24'h123456, 2'd1, 5'b00000, 24'hABCDEF, 2'd1, 2'd2, 4'h4, 3'b000));
    vecs.push_back(mk(24'h111111, 2'd0, 5'b00001, 24'hABCDEF, 2'd1, 2'd2, 4'h5, 3'b100));
    vecs.push_back(mk(24'h111111, 2'd0, 5'b00000, 24'hABCDEF, 2'd1, 2'd2, 4'h5, 3'b000));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00001, 24'hABCDEF, 2'd1, 2'd2, 4'hD, 3'b100));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00000, 24'hABCDEF, 2'd1, 2'd2, 4'hD, 3'b000));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00100, 24'hABCDEF, 2'd2, 2'd0, 4'hD, 3'b010));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00000, 24'h111111, 2'd2, 2'd0, 4'hD, 3'b000));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00000, 24'h111111, 2'd2, 2'd0, 4'hD, 3'b000));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00000, 24'h111111, 2'd2, 2'd0, 4'hD, 3'b000));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00000, 24'h111111, 2'd2, 2'd2, 4'hD, 3'b010));
    vecs.push_back(mk(24'h333333, 2'd3, 5'b00000, 24'hABCDEF, 2'd2, 2'd2, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00001, 24'hABCDEF, 2'd2, 2'd2, 4'hD, 3'b001));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'hABCDEF, 2'd2, 2'd2, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'hABCDEF, 2'd2, 2'd3, 4'hD, 3'b010));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'h333333, 2'd2, 2'd3, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'h333333, 2'd2, 2'd3, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'h333333, 2'd2, 2'd3, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'h333333, 2'd2, 2'd0, 4'hD, 3'b010));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'h111111, 2'd2, 2'd0, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00010, 24'h111111, 2'd2, 2'd0, 4'hD, 3'b001));
    vecs.push_back(mk(24'h555555, 2'd1, 5'b00000, 24'h111111, 2'd2, 2'd0, 4'hD, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd2, 5'b10010, 24'h111111, 2'd0, 2'd0, 4'h0, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd2, 5'b00000, 24'h555555, 2'd0, 2'd0, 4'h0, 3'b000));
    vecs.push_back(mk(24'h555555, 2'd2, 5'b00100, 24'h555555, 2'd0, 2'd0, 4'h0, 3'b001));
    vecs.push_back(mk(24'h555555, 2'd2, 5'b00000, 24'h555555, 2'd0, 2'd0, 4'h0, 3'b000));

    // Reset with save_req held high: no edge may be seen on release.
    reset            = 1'b1;
    bus.sensor_input = '0;
    bus.slot_sel     = '0;
    bus.save_req     = 1'b1;
    bus.load_req     = 1'b0;
    bus.play_req     = 1'b0;
    bus.live_req     = 1'b0;
    bus.clear_req    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_outs(-2, mk(24'h0, 2'd0, 5'b00001, 24'h0, 2'd0, 2'd0, 4'h0, 3'b000));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_outs(-1, mk(24'h0, 2'd0, 5'b00001, 24'h0, 2'd0, 2'd0, 4'h0, 3'b000));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset asserted mid-replay, one cycle before a step would occur.
    apply(100, mk(24'h777777, 2'd1, 5'b00001, 24'h777777, 2'd0, 2'd0, 4'h2, 3'b100));
    apply(101, mk(24'h777777, 2'd1, 5'b00000, 24'h777777, 2'd0, 2'd0, 4'h2, 3'b000));
    apply(102, mk(24'h777777, 2'd1, 5'b00100, 24'h777777, 2'd2, 2'd1, 4'h2, 3'b010));
    apply(103, mk(24'h777777, 2'd1, 5'b00000, 24'h777777, 2'd2, 2'd1, 4'h2, 3'b000));
    apply(104, mk(24'h777777, 2'd1, 5'b00000, 24'h777777, 2'd2, 2'd1, 4'h2, 3'b000));
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_outs(105, mk(24'h777777, 2'd1, 5'b00000, 24'h0, 2'd0, 2'd0, 4'h0, 3'b000));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_outs(106, mk(24'h777777, 2'd1, 5'b00000, 24'h777777, 2'd0, 2'd0, 4'h0, 3'b000));
    repeat (4) @(posedge clock);
    #1;
    check_outs(107, mk(24'h777777, 2'd1, 5'b00000, 24'h777777, 2'd0, 2'd0, 4'h0, 3'b000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sensor_snapshot_bank.md
Name: sensor_snapshot_bank

Overview:
- Parametrised successor to the fixed single-shot sensor save/load path between the sensor inputs, the processor and the VGA controller.
- Holds SLOTS snapshots of the DATA_W-bit sensor word and selects what the VGA controller shows:
  - the live sensor word,
  - one held snapshot,
  - or an automatic replay that cycles through all stored snapshots.
- Emits one-cycle save/load/error pulses to the processor.

Parameters:
DATA_W, 24, width of sensor word stored and displayed
SLOTS, 8, number of snapshot slots (power of two, >=2)
SLOT_W, $clog2(SLOTS), slot index width (derived, not overridden)
TICK_DIV, 50000000, clock cycles per replay step (>=1; 1 s at 50 MHz)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
sensor_input  in  DATA_W  live sensor word
slot_sel  in  SLOT_W  target slot for save/load
save_req  in  1  level request; action on rising edge
load_req  in  1  level request; action on rising edge
play_req  in  1  level request; action on rising edge
live_req  in  1  level request; action on rising edge
clear_req  in  1  level request; action on rising edge
display_data  out  DATA_W  word to VGA controller
mode  out  2  00=LIVE, 01=HOLD, 10=PLAY
cur_slot  out  SLOT_W  slot shown in HOLD/PLAY
valid_mask  out  SLOTS  bit i set = slot i holds data
save_signal  out  1  one-cycle pulse, save done
load_signal  out  1  one-cycle pulse, load or replay step done
err_signal  out  1  one-cycle pulse, request rejected

Behaviour:
- Reset (clock edge with reset=1):
  - Outputs: display_data=0, mode=LIVE, cur_slot=0, valid_mask=0, all pulses 0, tick counter=0.
  - Request-history registers are set to 1, so a request held high through reset produces no edge.
  - Slot memory contents are don't-care.
  - Reset mid-replay or mid-request aborts immediately; no pulse is issued.
- Edge detect: a request edge occurs when the input is sampled 1 and its history register is 0. The action and the pulse are registered: the pulse is high for exactly the one cycle after the edge sample.
- Simultaneous edges: only the highest-priority edge acts; the others in that cycle are dropped, not queued. Priority is clear > live > play > load > save.
- clear: valid_mask=0, mode=LIVE, cur_slot=0. No pulse.
- live: mode=LIVE, from any state. No pulse.
- play:
  - If valid_mask==0: err_signal, state unchanged.
  - Otherwise: mode=PLAY, cur_slot=lowest valid index, tick=0, load_signal.
- load:
  - If valid_mask[slot_sel]==1: mode=HOLD, cur_slot=slot_sel, load_signal.
  - Otherwise: err_signal, state unchanged.
  - Allowed from PLAY; exits replay.
- save:
  - In LIVE or HOLD: mem[slot_sel] <= sensor_input sampled in the edge cycle, valid_mask[slot_sel] set, save_signal.
  - In PLAY: err_signal, no write.
  - Overwriting an existing slot is legal.
  - In HOLD, saving to the slot being shown updates display_data one cycle later.
- PLAY stepping:
  - Tick counter increments every cycle in PLAY.
  - At count TICK_DIV-1 it resets to 0 and cur_slot advances to the next higher valid slot, wrapping to the lowest valid slot; load_signal pulses.
  - With a single valid slot, the step re-selects it and still pulses.
  - The counter is held at 0 outside PLAY.
- display_data is registered:
  - LIVE: sensor_input delayed 1 cycle.
  - HOLD/PLAY: mem[cur_slot] delayed 1 cycle after cur_slot changes.
- Memory: SLOTS x DATA_W registers, single write port, synchronous read.

Test Plan:
- (SLOTS=4, TICK_DIV=4) Reset with save_req held 1, then release → no save_signal, valid_mask=0000, mode=00, display_data=0.
- LIVE, sensor_input=0xABCDEF → display_data=0xABCDEF one cycle later. Pulse save_req with slot_sel=2 → save_signal one cycle later, valid_mask=0100.
- Change sensor to 0x123456, pulse load_req with slot_sel=2 → mode=01, cur_slot=2, load_signal, display_data=0xABCDEF. Pulse load_req with slot_sel=1 → err_signal, mode stays 01.
- Save 0x111111 to slot 0 and 0x333333 to slot 3, then play_req → cur_slot sequence 0,2,3,0 every 4 cycles with a load_signal at each step. display_data follows 0x111111, 0xABCDEF, 0x333333. save_req during PLAY → err_signal, memory unchanged.
- clear_req and load_req rising in the same cycle → only clear acts: valid_mask=0000, mode=00, no load_signal/err_signal. Then play_req → err_signal.
- Assert reset during PLAY between steps → next cycle mode=00, cur_slot=0, valid_mask=0000, no load_signal.
